// File: rtl/board_render_pkg.sv
// rtl/board_render_pkg.sv - shared codes, ASCII constants and render states for board_render
// Prompt state exists only when BOARD_RENDER_PROMPT_EN is defined.
package board_render_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_O     = 2'b01;
   localparam logic [1:0] CELL_X     = 2'b11;

   localparam logic [1:0] RES_NONE = 2'd0;
   localparam logic [1:0] RES_XWIN = 2'd1;
   localparam logic [1:0] RES_OWIN = 2'd2;
   localparam logic [1:0] RES_DRAW = 2'd3;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_BAR   = 8'h7C;
   localparam logic [7:0] ASCII_DASH  = 8'h2D;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_ONE   = 8'h31;

   localparam logic [2:0] PROMPT_LAST = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ROW    = 3'd1,
      ST_EOL    = 3'd2,
      ST_SEP    = 3'd3,
      ST_MSG    = 3'd4,
`ifdef BOARD_RENDER_PROMPT_EN
      ST_PROMPT = 3'd5,
`endif
      ST_DONE   = 3'd6
   } state_t;

   // Index of the last byte of a result line ("Draw\r\n" is 6 bytes, the win lines 8).
   function automatic logic [2:0] msg_last(input logic [1:0] res);
      return (res == RES_DRAW) ? 3'd5 : 3'd7;
   endfunction

endpackage

// File: rtl/board_render_cell_char.sv
// rtl/board_render_cell_char.sv - maps one 2-bit cell code and its index to an ASCII byte
module board_render_cell_char
   import board_render_pkg::*;
(
   input  logic [1:0] i_cell,
   input  logic [3:0] i_index,
   input  logic [7:0] i_x_char,
   input  logic [7:0] i_o_char,
   output logic [7:0] o_char
);

   always_comb begin
      case (i_cell)
         CELL_EMPTY: o_char = ASCII_ONE + 8'(i_index);
         CELL_O:     o_char = i_o_char;
         CELL_X:     o_char = i_x_char;
         default:    o_char = ASCII_QMARK;
      endcase
   end

endmodule

// File: rtl/board_render.sv
// rtl/board_render.sv - serialises a board snapshot and result into an ASCII byte stream
// Defining BOARD_RENDER_PROMPT_EN appends "Move? " to renders whose result is NONE.
module board_render
   import board_render_pkg::*;
#(
   parameter int unsigned ROW_SEP = 1,
   parameter logic [7:0]  X_CHAR  = 8'h58,
   parameter logic [7:0]  O_CHAR  = 8'h4F
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [17:0] i_board,
   input  logic [1:0]  i_result,
   output logic [7:0]  o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_busy,
   output logic        o_done
);

   state_t      state_q, state_d;
   logic [1:0]  row_q, row_d;
   logic [2:0]  col_q, col_d;
   logic [2:0]  idx_q, idx_d;
   logic [17:0] board_q, board_d;
   logic [1:0]  result_q, result_d;
   logic [3:0]  cell_idx;
   logic [1:0]  cell_code;
   logic [7:0]  cell_byte;
   logic [63:0] msg_str;
   logic [7:0]  msg_byte;

   // Even columns of a row are cells, odd columns are bars.
   assign cell_idx  = 4'(row_q) * 4'd3 + 4'(col_q[2:1]);
   assign cell_code = board_q[{cell_idx, 1'b0} +: 2];

   board_render_cell_char u_cell_char (
      .i_cell   (cell_code),
      .i_index  (cell_idx),
      .i_x_char (X_CHAR),
      .i_o_char (O_CHAR),
      .o_char   (cell_byte)
   );

   // Message ROM; the NONE entry holds the prompt text.
   always_comb begin
      case (result_q)
         RES_XWIN: msg_str = "X wins\r\n";
         RES_OWIN: msg_str = "O wins\r\n";
         RES_DRAW: msg_str = {"Draw\r\n", 16'h0000};
         default:  msg_str = {"Move? ", 16'h0000};
      endcase
   end
   assign msg_byte = msg_str[{~idx_q, 3'b111} -: 8];

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      idx_d    = idx_q;
      board_d  = board_q;
      result_d = result_q;
      o_data   = 8'h00;
      o_valid  = 1'b0;
      o_busy   = 1'b0;
      o_done   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               board_d  = i_board;
               result_d = i_result;
               row_d    = 2'd0;
               col_d    = 3'd0;
               idx_d    = 3'd0;
               state_d  = ST_ROW;
            end
         end
         ST_ROW: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            o_data  = col_q[0] ? ASCII_BAR : cell_byte;
            if (i_ready) begin
               if (col_q == 3'd4) begin
                  col_d   = 3'd0;
                  state_d = ST_EOL;
               end else begin
                  col_d = col_q + 3'd1;
               end
            end
         end
         ST_EOL: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            o_data  = col_q[0] ? ASCII_LF : ASCII_CR;
            if (i_ready) begin
               if (!col_q[0]) begin
                  col_d = 3'd1;
               end else begin
                  col_d = 3'd0;
                  if (row_q != 2'd2) begin
                     row_d = row_q + 2'd1;
                     if (ROW_SEP != 0) state_d = ST_SEP;
                     else              state_d = ST_ROW;
                  end else if (result_q != RES_NONE) begin
                     state_d = ST_MSG;
                  end else begin
`ifdef BOARD_RENDER_PROMPT_EN
                     state_d = ST_PROMPT;
`else
                     state_d = ST_DONE;
`endif
                  end
               end
            end
         end
         ST_SEP: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            if (col_q == 3'd5)      o_data = ASCII_CR;
            else if (col_q == 3'd6) o_data = ASCII_LF;
            else                    o_data = col_q[0] ? ASCII_PLUS : ASCII_DASH;
            if (i_ready) begin
               if (col_q == 3'd6) begin
                  col_d   = 3'd0;
                  state_d = ST_ROW;
               end else begin
                  col_d = col_q + 3'd1;
               end
            end
         end
         ST_MSG: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            o_data  = msg_byte;
            if (i_ready) begin
               if (idx_q == msg_last(result_q)) state_d = ST_DONE;
               else                             idx_d   = idx_q + 3'd1;
            end
         end
`ifdef BOARD_RENDER_PROMPT_EN
         ST_PROMPT: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            o_data  = msg_byte;
            if (i_ready) begin
               if (idx_q == PROMPT_LAST) state_d = ST_DONE;
               else                      idx_d   = idx_q + 3'd1;
            end
         end
`endif
         ST_DONE: begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         row_q    <= 2'd0;
         col_q    <= 3'd0;
         idx_q    <= 3'd0;
         board_q  <= 18'd0;
         result_q <= RES_NONE;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         idx_q    <= idx_d;
         board_q  <= board_d;
         result_q <= result_d;
      end
   end

endmodule
